// File: rtl/parent_hub_router.sv
// Parent-side hub of the 64-bit parent link: round-robin arbitration, unicast/broadcast fan-out.
// Optional macro HUB_DROP_STATS_EN adds a saturating drop_count output for invalid destinations.
module parent_hub_router #(
    parameter int         NUM_FPGAS = 5,
    parameter int         DEST_MSB  = 63,
    parameter logic [7:0] BCAST_ID  = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [64*(NUM_FPGAS+1)-1:0]     src_data,
    input  logic [NUM_FPGAS:0]              src_valid,
    output logic [NUM_FPGAS:0]              src_ready,
    output logic [64*(NUM_FPGAS+1)-1:0]     dst_data,
    output logic [NUM_FPGAS:0]              dst_valid,
    input  logic [NUM_FPGAS:0]              dst_ready,
    output logic                            busy
`ifdef HUB_DROP_STATS_EN
    ,
    output logic [15:0]                     drop_count
`endif
);
    localparam int P  = NUM_FPGAS + 1;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] last_grant_reg, last_grant_next;
    logic [63:0]   msg_reg, msg_next;
    logic [P-1:0]  pending_reg, pending_next;

    logic          grant_found;
    logic [PW-1:0] grant_idx;
    logic [P-1:0]  grant_onehot;
    logic [63:0]   grant_data;
    logic [7:0]    grant_dest;
    logic [P-1:0]  dest_mask;
    logic          drop;
    int            cand;

    // Rotating search starting just after the previous winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= P; k++) begin
            cand = (int'(last_grant_reg) + k) % P;
            if (!grant_found && src_valid[PW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign grant_data = src_data[int'(grant_idx)*64 +: 64];
    assign grant_dest = grant_data[DEST_MSB -: 8];

    // A port is a target if broadcast or directly addressed, but never the source itself.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_port
            assign grant_onehot[gi] = (grant_idx == PW'(gi));
            assign dest_mask[gi]    = ((grant_dest == BCAST_ID) || (grant_dest == 8'(gi)))
                                      && (grant_idx != PW'(gi));
            assign dst_data[gi*64 +: 64] = msg_reg;
        end
    endgenerate

    assign drop = grant_found && (dest_mask == '0);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        msg_next        = msg_reg;
        pending_next    = pending_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    last_grant_next = grant_idx;
                    msg_next        = grant_data;
                    if (!drop) begin
                        pending_next = dest_mask;
                        state_next   = SEND;
                    end
                end
            end
            SEND: begin
                pending_next = pending_reg & ~dst_ready;
                if (pending_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= PW'(NUM_FPGAS);
            msg_reg        <= '0;
            pending_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            msg_reg        <= msg_next;
            pending_reg    <= pending_next;
        end
    end

    // Gated by reset so a source never sees an accept that the registers will not honour.
    assign src_ready = (state_reg == IDLE && !reset && grant_found) ? grant_onehot : '0;
    assign dst_valid = (state_reg == SEND) ? pending_reg : '0;
    assign busy      = (state_reg == SEND);

`ifdef HUB_DROP_STATS_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_reg <= '0;
        end else if (state_reg == IDLE && drop && drop_count_reg != 16'hFFFF) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

endmodule

// File: tb/tb_parent_hub_router.sv
// Testbench for parent_hub_router: directed scenarios plus random traffic against a message-level model.
module tb_parent_hub_router;
    localparam int NUM_FPGAS = 5;
    localparam int P = NUM_FPGAS + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [64*P-1:0]    src_data;
    logic [P-1:0]       src_valid;
    logic [P-1:0]       src_ready;
    logic [64*P-1:0]    dst_data;
    logic [P-1:0]       dst_valid;
    logic [P-1:0]       dst_ready;
    logic               busy;
`ifdef HUB_DROP_STATS_EN
    logic [15:0]        drop_count;
`endif

    always #5 clk = ~clk;

    parent_hub_router #(.NUM_FPGAS(NUM_FPGAS), .DEST_MSB(63), .BCAST_ID(8'hFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .busy      (busy)
`ifdef HUB_DROP_STATS_EN
        ,
        .drop_count(drop_count)
`endif
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Per-source message queues; a source holds valid while its queue is non-empty.
    logic [63:0] srcq [P][$];

    // Message-level model: one held message plus the set of ports still owed a copy.
    bit          m_busy;
    logic [P-1:0] m_pending;
    logic [63:0] m_msg;
    int          m_last;
    int          m_drops;

    logic [P-1:0]    s_src_ready, s_dst_valid;
    logic            s_busy;
    logic [64*P-1:0] s_dst_data;
    int              glog[$];
    int              gcyc[$];
    int              cycle = 0;

    function automatic int model_grant(input logic [P-1:0] v, input int last);
        for (int k = 1; k <= P; k++) begin
            if (v[(last + k) % P]) return (last + k) % P;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rand_msg();
        int r;
        logic [7:0] d;
        r = $urandom_range(0, 99);
        if (r < 65)      d = 8'($urandom_range(0, NUM_FPGAS));
        else if (r < 80) d = 8'hFF;
        else             d = 8'($urandom_range(NUM_FPGAS + 1, 254));
        return {d, 32'($urandom), 24'($urandom)};
    endfunction

    task automatic step(input logic [P-1:0] rdy, input logic rst);
        logic [P-1:0] exp_ready, exp_valid;
        logic [63:0]  msg;
        int g, d, idx;
        reset     = rst;
        dst_ready = rdy;
        for (int p = 0; p < P; p++) begin
            src_valid[p] = (srcq[p].size() > 0);
            src_data[64*p +: 64] = (srcq[p].size() > 0) ? srcq[p][0] : {32'($urandom), 32'($urandom)};
        end
        @(negedge clk);
        cycle++;
        g = (rst || m_busy) ? -1 : model_grant(src_valid, m_last);
        exp_ready = '0;
        if (g >= 0) exp_ready = P'(1) << g;
        exp_valid = m_busy ? m_pending : '0;
        check_val("src_ready", 64'(src_ready), 64'(exp_ready));
        check_val("dst_valid", 64'(dst_valid), 64'(exp_valid));
        check_val("busy", 64'(busy), 64'(m_busy));
        for (int p = 0; p < P; p++) begin
            if (exp_valid[p]) check_val("dst_data", dst_data[64*p +: 64], m_msg);
        end
`ifdef HUB_DROP_STATS_EN
        check_val("drop_count", 64'(drop_count), 64'(m_drops));
`endif
        s_src_ready = src_ready;
        s_dst_valid = dst_valid;
        s_busy      = busy;
        s_dst_data  = dst_data;
        idx = -1;
        for (int p = 0; p < P; p++) if (src_ready[p]) idx = p;
        if (idx >= 0) begin
            glog.push_back(idx);
            gcyc.push_back(cycle);
        end
        if (rst) begin
            m_busy = 0; m_pending = '0; m_last = NUM_FPGAS; m_drops = 0;
        end else if (m_busy) begin
            m_pending = m_pending & ~rdy;
            if (m_pending == '0) m_busy = 0;
        end else if (g >= 0) begin
            msg    = srcq[g].pop_front();
            d      = int'(msg[63:56]);
            m_last = g;
            m_msg  = msg;
            if (d == 255)                      m_pending = {P{1'b1}} & ~(P'(1) << g);
            else if (d <= NUM_FPGAS && d != g) m_pending = P'(1) << d;
            else                               m_pending = '0;
            if (m_pending != '0) m_busy = 1;
            else if (m_drops < 65535) m_drops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step('0, 1'b1);
        glog.delete();
        gcyc.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] bmsg;
        int total;
        reset = 1'b1; dst_ready = '0; src_valid = '0; src_data = '0;
        m_busy = 0; m_pending = '0; m_msg = '0; m_last = NUM_FPGAS; m_drops = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        step('1, 1'b0);
        for (int p = 0; p < P; p++) check_val("rst_dst_data", s_dst_data[64*p +: 64], 64'h0);
        check_val("rst_busy", 64'(s_busy), 64'h0);

        // Unicast root -> port 3
        srcq[0].push_back(64'h03AA_0000_0000_1234);
        step('1, 1'b0);
        check_val("uc_src_ready", 64'(s_src_ready), 64'h01);
        step('1, 1'b0);
        check_val("uc_dst_valid", 64'(s_dst_valid), 64'h08);
        check_val("uc_data", s_dst_data[64*3 +: 64], 64'h03AA_0000_0000_1234);
        step('1, 1'b0);
        check_val("uc_idle", 64'(s_busy), 64'h0);

        // Broadcast from port 2 with port 4 stalled for three cycles
        do_reset();
        bmsg = 64'hFF12_3456_789A_BCDE;
        srcq[2].push_back(bmsg);
        step('1, 1'b0);
        check_val("bc_src_ready", 64'(s_src_ready), 64'h04);
        step(6'b101111, 1'b0);
        check_val("bc_first_valid", 64'(s_dst_valid), 64'h3B);
        for (int i = 0; i < 2; i++) begin
            step(6'b101111, 1'b0);
            check_val("bc_wait_valid", 64'(s_dst_valid), 64'h10);
            check_val("bc_wait_data", s_dst_data[64*4 +: 64], bmsg);
            check_val("bc_wait_busy", 64'(s_busy), 64'h1);
        end
        step('1, 1'b0);
        check_val("bc_last_valid", 64'(s_dst_valid), 64'h10);
        step('1, 1'b0);
        check_val("bc_done_busy", 64'(s_busy), 64'h0);

        // Round-robin with every port continuously valid
        do_reset();
        for (int r = 0; r < 2; r++) begin
            srcq[0].push_back({8'h01, 32'($urandom), 24'($urandom)});
            for (int p = 1; p < P; p++) srcq[p].push_back({8'h00, 32'($urandom), 24'($urandom)});
        end
        for (int i = 0; i < 26; i++) step('1, 1'b0);
        check_val("rr_count", 64'(glog.size()), 64'(2*P));
        for (int k = 0; k < glog.size() && k < 2*P; k++) begin
            check_val("rr_order", 64'(glog[k]), 64'(k % P));
            if (k > 0) check_val("rr_gap", 64'(gcyc[k] - gcyc[k-1]), 64'd2);
        end

        // Invalid and self-addressed destinations from child 1
        do_reset();
        srcq[1].push_back({8'h09, 56'h1});
        srcq[1].push_back({8'h01, 56'h2});
        for (int i = 0; i < 3; i++) begin
            step('1, 1'b0);
            check_val("inv_busy", 64'(s_busy), 64'h0);
            check_val("inv_valid", 64'(s_dst_valid), 64'h0);
        end
        check_val("inv_accepts", 64'(glog.size()), 64'd2);
`ifdef HUB_DROP_STATS_EN
        check_val("inv_drop_count", 64'(drop_count), 64'd2);
`endif

        // Reset in the middle of a stalled unicast
        do_reset();
        srcq[0].push_back({8'h03, 56'hABC});
        step('0, 1'b0);
        srcq[0].push_back({8'h02, 56'hDEF});
        srcq[3].push_back({8'h00, 56'h123});
        step('0, 1'b1);
        check_val("rs_valid_during", 64'(s_dst_valid), 64'h08);
        step('1, 1'b0);
        check_val("rs_valid_after", 64'(s_dst_valid), 64'h0);
        check_val("rs_busy_after", 64'(s_busy), 64'h0);
        check_val("rs_next_grant", 64'(s_src_ready), 64'h01);
        for (int i = 0; i < 6; i++) step('1, 1'b0);

        // Random traffic with random backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [P-1:0] rdy;
            if ($urandom_range(0, 99) < 40) srcq[$urandom_range(0, P-1)].push_back(rand_msg());
            for (int p = 0; p < P; p++) rdy[p] = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 999) == 0) step(rdy, 1'b1);
            else step(rdy, 1'b0);
        end
        for (int i = 0; i < 400; i++) begin
            total = 0;
            for (int p = 0; p < P; p++) total += srcq[p].size();
            if (total == 0 && !m_busy) break;
            step('1, 1'b0);
        end
        total = 0;
        for (int p = 0; p < P; p++) total += srcq[p].size();
        check_val("rand_drained", 64'(total), 64'h0);

`ifdef HUB_DROP_STATS_EN
        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 65540; i++) srcq[1].push_back({8'h09, 56'(i)});
        for (int i = 0; i < 65540; i++) step('1, 1'b0);
        check_val("sat_drop_count", 64'(drop_count), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/parent_hub_router.md
Name: parent_hub_router

Overview:
- Parent-side end of the 64-bit parent link used by every per-FPGA Helios core.
- Port 0 is the root controller. Ports 1..NUM_FPGAS are the children: each child's parent_tx feeds this block, and this block drives each child's parent_rx.
- Carries one 64-bit message at a time from an arbitrated source to a unicast destination or to a broadcast set.
- Never modifies the message payload.

Parameters:
- NUM_FPGAS, 5: number of child FPGAs; total ports P = NUM_FPGAS+1.
- DEST_MSB, 63: MSB of the 8-bit destination field, which occupies [DEST_MSB:DEST_MSB-7].
- BCAST_ID, 8'hFF: destination value meaning "all ports except the source".

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src_data  in  64*P  message from port p at [64p+63:64p]
- src_valid  in  P  port p has a message
- src_ready  out  P  one-hot accept pulse to the winning source
- dst_data  out  64*P  message to port p; the same latched message is driven on all lanes
- dst_valid  out  P  per-destination valid
- dst_ready  in  P  per-destination ready
- busy  out  1  high while a message is held (state SEND)
- drop_count  out  16  invalid-destination counter; exists only with HUB_DROP_STATS_EN

Behaviour:
- Port ID equals port index: 0 = root, 1..NUM_FPGAS = children.
- Reset values: src_ready=0, dst_valid=0, busy=0, dst_data=0, last_grant=NUM_FPGAS (so port 0 has first priority), state=IDLE, drop_count=0.
- State IDLE:
  - If any src_valid is set, grant the first valid port searching from last_grant+1 upward, wrapping mod P.
  - Pulse src_ready[g] for exactly that cycle. The transfer completes in that cycle because src_valid[g] is already high.
  - Latch data into msg and set last_grant=g.
  - Compute the destination mask:
    - dest==BCAST_ID: all ports except g.
    - dest<=NUM_FPGAS and dest!=g: one-hot at dest.
    - dest==g (self-addressed): invalid.
    - otherwise: invalid.
  - Valid mask: go to SEND. Invalid mask: drop the message, stay in IDLE, increment drop_count if HUB_DROP_STATS_EN.
  - If no src_valid is set, src_ready=0 and the state is unchanged.
- State SEND:
  - dst_valid = pending mask; busy=1; src_ready=0.
  - For each p with dst_valid[p] && dst_ready[p], clear pending[p] at the clock edge.
  - When the next pending mask is zero, return to IDLE.
  - dst_valid[p] drops the cycle after its handshake. Other destinations keep waiting independently, so a slow child never duplicates delivery to others.
  - dst_data is stable for the whole of SEND.
- Latency and throughput:
  - Accept at cycle T, dst_valid high at T+1.
  - Unicast with the destination ready costs 2 cycles per message (IDLE+SEND).
  - Next accept is no earlier than the cycle after the last handshake.
- Simultaneous events: src_valid arriving during SEND is ignored until IDLE; the source holds valid.
- Arbitration fairness: with all ports continuously valid, grants rotate 0,1,...,NUM_FPGAS,0,...
- Wrap-around: drop_count saturates at 16'hFFFF.
- Reset mid-operation: the held message is discarded, dst_valid=0 the next cycle, pending is cleared, and last_grant returns to NUM_FPGAS. No partial broadcast resumes.
- Width rule: the destination compare is 8-bit, and NUM_FPGAS must be less than 255.

Optional Feature:
- Macro HUB_DROP_STATS_EN.
- Defined: the drop_count port exists and counts invalid-destination and self-addressed drops, saturating at 16'hFFFF.
- Undefined: the port is absent and drops are silent. Routing and timing are identical in both cases.

Test Plan:
- Unicast: root sends 64'h03AA_0000_0000_1234 on port 0 with all dst_ready=1 -> src_ready[0] pulses at T, dst_valid=6'b001000 at T+1 with the same data, IDLE at T+2.
- Broadcast with backpressure: port 2 sends dest 8'hFF; dst_ready[4]=0 for 3 cycles -> ports 0,1,3,5 handshake at T+1 and drop valid; port 4 stays valid with stable data until ready; busy=1 throughout; port 2 never sees valid.
- Round-robin: all 6 src_valid held high, each message to root (port 0 sends to 1) -> grant order 0,1,2,3,4,5,0 with one grant every 2 cycles.
- Invalid destination: child 1 sends dest 8'h09 (NUM_FPGAS=5), then dest 8'h01 -> both accepted, no dst_valid, busy stays 0; with HUB_DROP_STATS_EN, drop_count=2.
- Reset mid-send: reset asserted at T+1 of a unicast while dst_ready=0 -> dst_valid=0 and busy=0 at T+2; the next grant goes to port 0 if valid.
- Saturation (HUB_DROP_STATS_EN): 65540 invalid messages -> drop_count holds at 16'hFFFF.
